// File: rtl/m_imem_cache_resp_pkg.sv
// Shared definitions for the instruction-fetch cache responder: NOP constant,
// FSM encoding, address-width derivations and a saturating increment.
package m_imem_cache_resp_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_e;

    function automatic int f_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int f_idxw(input int lines);
        return f_log2(lines);
    endfunction

    // Word address is pc[31:2]; whatever the index does not cover is tag.
    function automatic int f_tagw(input int lines);
        return 30 - f_log2(lines);
    endfunction

    function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/m_imem_cache_resp_if.sv
// Fetch-side bus between processor (master) and instruction cache (slave).
interface m_imem_cache_resp_if;
    logic [31:0] w_pc;
    logic        w_inv;
    logic [31:0] w_ir;
    logic        w_stall;
    logic [31:0] w_hit_cnt;
    logic [31:0] w_miss_cnt;

    modport master (
        output w_pc, w_inv,
        input  w_ir, w_stall, w_hit_cnt, w_miss_cnt
    );

    modport slave (
        input  w_pc, w_inv,
        output w_ir, w_stall, w_hit_cnt, w_miss_cnt
    );
endinterface

// File: rtl/m_icache_array.sv
// Direct-mapped line storage: {valid, tag, data} per line, combinational read,
// single write port and a global valid clear where the write wins for its line.
module m_icache_array
    import m_imem_cache_resp_pkg::*;
#(
    parameter int  LINES = 8,
    localparam int IDXW  = f_idxw(LINES),
    localparam int TAGW  = f_tagw(LINES)
) (
    input  logic            w_clk,
    input  logic            w_rst_n,
    input  logic [IDXW-1:0] rd_idx_i,
    output logic            rd_valid_o,
    output logic [TAGW-1:0] rd_tag_o,
    output logic [31:0]     rd_data_o,
    input  logic            we_i,
    input  logic [IDXW-1:0] wr_idx_i,
    input  logic [TAGW-1:0] wr_tag_i,
    input  logic [31:0]     wr_data_i,
    input  logic            clr_i
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAGW-1:0]  tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_comb begin
        valid_d = clr_i ? '0 : valid_q;
        if (we_i) valid_d[wr_idx_i] = 1'b1;
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) valid_q <= '0;
        else          valid_q <= valid_d;
    end

    // Tag and data carry no reset; the valid bit alone qualifies them.
    always_ff @(posedge w_clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/m_imem_cache_resp.sv
// Instruction-fetch responder: zero-latency hits from a direct-mapped cache,
// fixed-penalty fills from the word-array backing store, hit/miss counters.
module m_imem_cache_resp
    import m_imem_cache_resp_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LINES     = 8,
    parameter int MISS_LAT  = 4
) (
    input  logic               w_clk,
    input  logic               w_rst_n,
    m_imem_cache_resp_if.slave bus
);

    localparam int IDXW = f_idxw(LINES);
    localparam int TAGW = f_tagw(LINES);
    localparam int AW   = f_log2(MEM_WORDS);
    localparam int CNTW = f_log2(MISS_LAT) + 1;

    // Backing store, loaded from outside; never cleared by reset.
    logic [31:0] mem [MEM_WORDS];

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   fill_addr_q, fill_addr_d;
    logic [IDXW-1:0] fill_idx_q, fill_idx_d;
    logic [TAGW-1:0] fill_tag_q, fill_tag_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    logic [IDXW-1:0] pc_idx;
    logic [TAGW-1:0] pc_tag;
    logic [AW-1:0]   pc_addr;
    logic            unused_pc_lsb;

    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic [31:0]     rd_data;
    logic            hit;
    logic            fill_we;
    logic [31:0]     fill_data;

    assign pc_idx        = bus.w_pc[2+IDXW-1:2];
    assign pc_tag        = bus.w_pc[31:2+IDXW];
    assign pc_addr       = bus.w_pc[2+AW-1:2];
    assign unused_pc_lsb = ^bus.w_pc[1:0];

    m_icache_array #(
        .LINES(LINES)
    ) u_array (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .rd_idx_i   (pc_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (fill_we),
        .wr_idx_i   (fill_idx_q),
        .wr_tag_i   (fill_tag_q),
        .wr_data_i  (fill_data),
        .clr_i      (bus.w_inv)
    );

    // Reset low forces a miss view so the processor stays frozen.
    assign hit = w_rst_n && (state_q == S_IDLE) && rd_valid &&
                 (rd_tag == pc_tag) && !bus.w_inv;

    assign fill_we   = w_rst_n && (state_q == S_FILL) && (cnt_q == '0);
    assign fill_data = mem[fill_addr_q];

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge w_clk) begin
        fill_addr_q <= fill_addr_d;
        fill_idx_q  <= fill_idx_d;
        fill_tag_q  <= fill_tag_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_addr_d = fill_addr_q;
        fill_idx_d  = fill_idx_q;
        fill_tag_d  = fill_tag_q;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    state_d     = S_FILL;
                    cnt_d       = CNTW'(MISS_LAT - 1);
                    fill_addr_d = pc_addr;
                    fill_idx_d  = pc_idx;
                    fill_tag_d  = pc_tag;
                end
            end
            S_FILL: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNTW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit_cnt_d  = hit ? f_sat_inc(hit_cnt_q) : hit_cnt_q;
        miss_cnt_d = ((state_q == S_IDLE) && !hit) ? f_sat_inc(miss_cnt_q) : miss_cnt_q;
    end

    always_comb begin
        bus.w_stall    = !hit;
        bus.w_ir       = hit ? rd_data : NOP;
        bus.w_hit_cnt  = hit_cnt_q;
        bus.w_miss_cnt = miss_cnt_q;
    end

endmodule

// File: tb/tb_m_imem_cache_resp.sv
// Bench for m_imem_cache_resp: directed table, hand sequences and random
// traffic, all compared against a line/penalty model of the cache.
module tb_m_imem_cache_resp;

    localparam int MW = 1024;
    localparam int LN = 8;
    localparam int ML = 4;
    localparam int IW = 3;
    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic w_clk = 1'b0;
    logic rst_n_drv = 1'b0;

    m_imem_cache_resp_if bus();

    m_imem_cache_resp #(.MEM_WORDS(MW), .LINES(LN), .MISS_LAT(ML)) dut (
        .w_clk   (w_clk),
        .w_rst_n (rst_n_drv),
        .bus     (bus)
    );

    always #5 w_clk = ~w_clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] tbmem [MW];
    logic        m_valid [LN];
    logic [31:0] m_tag   [LN];
    logic [31:0] m_data  [LN];
    int          m_busy;
    logic [31:0] m_fill_pc;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    logic        last_stall;
    logic [31:0] last_ir;

    typedef struct {
        logic [31:0] pc;
        logic        inv;
        logic        rst_n;
        logic        stall;
        logic [31:0] ir;
    } vec_t;
    vec_t tbl [8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int unsigned midx(input logic [31:0] pc);
        return (pc >> 2) % LN;
    endfunction

    function automatic logic m_hit(input logic [31:0] pc, input logic inv, input logic rst);
        int unsigned i;
        i = midx(pc);
        return rst && (m_busy == 0) && m_valid[i] && (m_tag[i] == (pc >> (2 + IW))) && !inv;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < LN; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void m_edge(input logic [31:0] pc, input logic inv, input logic rst, input logic h);
        int unsigned fi;
        if (!rst) begin
            m_clear();
            m_busy = 0;
            m_hits = 0;
            m_misses = 0;
        end else if (m_busy == 0) begin
            if (h) begin
                if (m_hits != 32'hFFFF_FFFF) m_hits++;
            end else begin
                if (m_misses != 32'hFFFF_FFFF) m_misses++;
                m_busy = ML;
                m_fill_pc = pc;
            end
            if (inv) m_clear();
        end else begin
            if (inv) m_clear();
            m_busy--;
            if (m_busy == 0) begin
                fi = midx(m_fill_pc);
                m_valid[fi] = 1'b1;
                m_tag[fi]   = m_fill_pc >> (2 + IW);
                m_data[fi]  = tbmem[(m_fill_pc >> 2) % MW];
            end
        end
    endfunction

    // One clock cycle: drive, check outputs mid-cycle against the model, advance.
    task automatic cycle(input logic [31:0] pc, input logic inv, input logic rst);
        logic h;
        bus.w_pc  = pc;
        bus.w_inv = inv;
        rst_n_drv = rst;
        @(negedge w_clk);
        h = m_hit(pc, inv, rst);
        check("stall", 32'(bus.w_stall), 32'(!h));
        check("ir", bus.w_ir, h ? m_data[midx(pc)] : NOP_I);
        check("hit_cnt", bus.w_hit_cnt, m_hits);
        check("miss_cnt", bus.w_miss_cnt, m_misses);
        last_stall = bus.w_stall;
        last_ir    = bus.w_ir;
        @(posedge w_clk);
        m_edge(pc, inv, rst, h);
        #1;
    endtask

    task automatic do_reset();
        cycle(32'h0, 1'b0, 1'b0);
        cycle(32'h0, 1'b0, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] pc, output int stalls, output logic [31:0] ir);
        stalls = 0;
        ir = NOP_I;
        for (int k = 0; k < 20; k++) begin
            cycle(pc, 1'b0, 1'b1);
            if (!last_stall) begin
                ir = last_ir;
                return;
            end
            stalls++;
        end
        n_cmp++;
        n_err++;
        $display("FAIL fetch_timeout: pc %h still stalled after 20 cycles, expected release", pc);
    endtask

    int st;
    logic [31:0] ir;

    initial begin
        for (int i = 0; i < MW; i++) begin
            tbmem[i] = $urandom;
        end
        tbmem[0] = 32'h0010_0093;
        for (int i = 0; i < MW; i++) dut.mem[i] = tbmem[i];
        for (int i = 0; i < LN; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_data[i]  = '0;
        end
        m_busy = 0; m_fill_pc = '0; m_hits = '0; m_misses = '0;
        bus.w_pc = '0;
        bus.w_inv = 1'b0;
        @(posedge w_clk);
        #1;

        // Table: reset then first fetch of PC 0.
        tbl[0] = '{32'h0, 1'b0, 1'b0, 1'b1, NOP_I};
        for (int i = 1; i <= 5; i++) tbl[i] = '{32'h0, 1'b0, 1'b1, 1'b1, NOP_I};
        tbl[6] = '{32'h0, 1'b0, 1'b1, 1'b0, 32'h0010_0093};
        tbl[7] = '{32'h0, 1'b0, 1'b1, 1'b0, 32'h0010_0093};
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].pc, tbl[i].inv, tbl[i].rst_n);
            check("tbl_stall", 32'(last_stall), 32'(tbl[i].stall));
            check("tbl_ir", last_ir, tbl[i].ir);
            if (i == 6) begin
                check("t1_hit", bus.w_hit_cnt, 32'd1);
                check("t1_miss", bus.w_miss_cnt, 32'd1);
            end
        end

        // Sequential fill then zero-stall second pass.
        do_reset();
        for (int p = 0; p < 8; p++) begin
            fetch(32'(p * 4), st, ir);
            check("seq_fill_stalls", 32'(st), 32'd5);
            check("seq_fill_ir", ir, tbmem[p]);
        end
        for (int p = 0; p < 8; p++) begin
            fetch(32'(p * 4), st, ir);
            check("seq_hit_stalls", 32'(st), 32'd0);
        end
        check("seq_hit_cnt", bus.w_hit_cnt, 32'd16);
        check("seq_miss_cnt", bus.w_miss_cnt, 32'd8);

        // Alias on the same index.
        do_reset();
        fetch(32'h00, st, ir);
        fetch(32'h20, st, ir);
        check("alias_ir20", ir, tbmem[8]);
        fetch(32'h00, st, ir);
        check("alias_stalls", 32'(st), 32'd5);
        check("alias_ir0", ir, tbmem[0]);
        check("alias_miss", bus.w_miss_cnt, 32'd3);

        // Invalidate pulse while hitting.
        do_reset();
        fetch(32'h08, st, ir);
        fetch(32'h04, st, ir);
        cycle(32'h04, 1'b0, 1'b1);
        check("inv_prehit", 32'(last_stall), 32'd0);
        cycle(32'h04, 1'b1, 1'b1);
        check("inv_stall", 32'(last_stall), 32'd1);
        fetch(32'h04, st, ir);
        check("inv_rest_stalls", 32'(st), 32'(ML));
        check("inv_ir", ir, tbmem[1]);
        check("inv_miss", bus.w_miss_cnt, 32'd3);
        fetch(32'h08, st, ir);
        check("inv_other_stalls", 32'(st), 32'd5);
        check("inv_miss2", bus.w_miss_cnt, 32'd4);

        // Reset asserted in the second fill cycle.
        do_reset();
        cycle(32'h0C, 1'b0, 1'b1);
        cycle(32'h0C, 1'b0, 1'b1);
        cycle(32'h0C, 1'b0, 1'b0);
        check("rst_fill_stall", 32'(last_stall), 32'd1);
        check("rst_hit0", bus.w_hit_cnt, 32'd0);
        check("rst_miss0", bus.w_miss_cnt, 32'd0);
        fetch(32'h0C, st, ir);
        check("rst_refetch_stalls", 32'(st), 32'd5);
        check("rst_refetch_ir", ir, tbmem[3]);

        // PC beyond the backing store wraps but keeps its own tag.
        do_reset();
        fetch(32'h08, st, ir);
        fetch(32'(4 * MW + 8), st, ir);
        check("wrap_stalls", 32'(st), 32'd5);
        check("wrap_ir", ir, tbmem[2]);
        fetch(32'h08, st, ir);
        check("wrap_back_stalls", 32'(st), 32'd5);
        check("wrap_miss", bus.w_miss_cnt, 32'd3);

        // Random traffic, including PC changes mid-fill, invalidates and resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] pc;
            pc = 32'($urandom_range(0, 23) * 4) + 32'($urandom_range(0, 2) * 4 * MW);
            if ($urandom_range(0, 3) != 0 && last_stall) pc = bus.w_pc;
            cycle(pc, ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
